// File: rtl/mul_shadd32u.sv
// Radix-4 shift-add unsigned 32x32 multiplier: 2 multiplier bits per Loop cycle, 64-bit exact product.
// Optional early termination when the remaining multiplier is zero: define MUL_EARLY_TERM_EN.
module mul_shadd32u (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic        start_in,
  output logic [63:0] p_out,
  output logic        busy
);

  // state  | meaning
  // FINISH | idle, p_out holds the last result (unused code 2'b11 also lands here)
  // PREP   | load operands, precompute 3A
  // LOOP   | add 0/A/2A/3A at weight 4^count, shift multiplier right by 2
  typedef enum logic [1:0] {
    FINISH = 2'b00,
    PREP   = 2'b01,
    LOOP   = 2'b10
  } state_t;

  state_t      state;
  logic [63:0] acc;
  logic [31:0] mult;
  logic [33:0] a3;
  logic [4:0]  count;

  logic [33:0] a_x3;
  logic [33:0] multiple;
  logic [63:0] addend;
  logic [63:0] acc_next;
  logic        last_iter;

  assign a_x3 = {2'b00, a_in} + {1'b0, a_in, 1'b0};

  always_comb begin
    multiple = 34'd0;
    case (mult[1:0])
      2'd0: multiple = 34'd0;
      2'd1: multiple = {2'b00, a_in};
      2'd2: multiple = {1'b0, a_in, 1'b0};
      2'd3: multiple = a3;
      default: multiple = 34'd0;
    endcase
  end

  // Largest weight is 4^15 and the largest multiple is below 2^34, so the sum never exceeds 64 bits.
  assign addend   = {30'd0, multiple} << {count, 1'b0};
  assign acc_next = acc + addend;

`ifdef MUL_EARLY_TERM_EN
  assign last_iter = (count == 5'd15) || (mult[31:2] == 30'd0);
`else
  assign last_iter = (count == 5'd15);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FINISH;
      busy  <= 1'b0;
      p_out <= 64'd0;
      acc   <= 64'd0;
      count <= 5'd0;
      mult  <= 32'd0;
      a3    <= 34'd0;
    end else begin
      case (state)
        PREP: begin
          acc   <= 64'd0;
          mult  <= b_in;
          a3    <= a_x3;
          count <= 5'd0;
          state <= LOOP;
        end
        LOOP: begin
          acc   <= acc_next;
          mult  <= mult >> 2;
          count <= count + 5'd1;
          if (last_iter) begin
            state <= FINISH;
            busy  <= 1'b0;
            p_out <= acc_next;
          end
        end
        default: begin
          state <= FINISH;
          busy  <= 1'b0;
          if (start_in) begin
            if ((a_in != 32'd0) && (b_in != 32'd0)) begin
              state <= PREP;
              busy  <= 1'b1;
            end else begin
              p_out <= 64'd0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_shadd32u.sv
// Directed self-checking bench for mul_shadd32u; expected busy lengths follow MUL_EARLY_TERM_EN.
module tb_mul_shadd32u;

  logic        clk;
  logic        rst;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        start_in;
  logic [63:0] p_out;
  logic        busy;

  int          checks;
  int          errors;
  int          cyc;
  int          idle;
  bit          stable;
  logic [63:0] p_prev;

`ifdef MUL_EARLY_TERM_EN
  localparam int BUSY_7X3    = 2;
  localparam int BUSY_B10    = 4;
  localparam int BUSY_B3001  = 8;
  localparam int BUSY_B2     = 2;
  localparam int BUSY_B10000 = 10;
`else
  localparam int BUSY_7X3    = 17;
  localparam int BUSY_B10    = 17;
  localparam int BUSY_B3001  = 17;
  localparam int BUSY_B2     = 17;
  localparam int BUSY_B10000 = 17;
`endif

  mul_shadd32u dut (
    .clk      (clk),
    .rst      (rst),
    .a_in     (a_in),
    .b_in     (b_in),
    .start_in (start_in),
    .p_out    (p_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Starts an operation at a negedge, counts busy cycles and checks p_out holds while busy.
  // poke>0 re-asserts start_in during that busy cycle (1 = Prep, 2 = first Loop cycle).
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int exp_busy, input logic [63:0] exp_p, input int poke);
    logic [63:0] prev;
    int          n;
    bit          hold;
    prev     = p_out;
    a_in     = a;
    b_in     = b;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    n    = 0;
    hold = 1'b1;
    while (busy && n < 200) begin
      n++;
      if (p_out !== prev) hold = 1'b0;
      start_in = (n == poke);
      @(negedge clk);
    end
    start_in = 1'b0;
    check({tag, "_busy_cycles"}, 64'(n), 64'(exp_busy));
    check({tag, "_product"}, p_out, exp_p);
    check({tag, "_hold"}, {63'd0, hold}, 64'd1);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    start_in = 1'b0;
    a_in     = 32'd0;
    b_in     = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_p", p_out, 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", {63'd0, busy}, 64'd0);
    check("idle_p", p_out, 64'd0);

    run_op("full_width", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 17, 64'hFFFF_FFFE_0000_0001, 0);
    run_op("seven_x_three", 32'd7, 32'd3, BUSY_7X3, 64'd21, 0);

    // Zero bypass: stays idle, p_out cleared at the start edge.
    a_in     = 32'd0;
    b_in     = 32'd5;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    check("bypass_a0_busy", {63'd0, busy}, 64'd0);
    check("bypass_a0_p", p_out, 64'd0);
    @(negedge clk);
    check("bypass_a0_busy_later", {63'd0, busy}, 64'd0);

    run_op("shift_by_16", 32'h1234_5678, 32'h0000_0010, BUSY_B10, 64'h0000_0001_2345_6780, 0);

    a_in     = 32'd9;
    b_in     = 32'd0;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    check("bypass_b0_busy", {63'd0, busy}, 64'd0);
    check("bypass_b0_p", p_out, 64'd0);

    // Start re-asserted in Loop cycle 3 must be ignored.
    run_op("ignored_start", 32'h0000_1000, 32'h0000_3001, BUSY_B3001, 64'h0000_0000_0300_1000, 4);

    // Reset in Loop cycle 5 aborts the operation.
    a_in     = 32'hFFFF_FFFF;
    b_in     = 32'hFFFF_FFFF;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    repeat (5) @(negedge clk);
    check("midloop_busy_before_rst", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midloop_rst_busy", {63'd0, busy}, 64'd0);
    check("midloop_rst_p", p_out, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_idle", {63'd0, busy}, 64'd0);

    run_op("after_rst_op", 32'hFFFF_FFFF, 32'h0000_0002, BUSY_B2, 64'h0000_0001_FFFF_FFFE, 0);

    // Back-to-back with start held high.
    a_in     = 32'h0001_0000;
    b_in     = 32'h0001_0000;
    start_in = 1'b1;
    for (int op = 0; op < 2; op++) begin
      p_prev = p_out;
      idle   = 0;
      cyc    = 0;
      stable = 1'b1;
      while (!busy && idle < 50) begin
        idle++;
        @(negedge clk);
      end
      while (busy && cyc < 200) begin
        cyc++;
        if (p_out !== p_prev) stable = 1'b0;
        @(negedge clk);
      end
      check($sformatf("b2b%0d_idle_cycles", op), 64'(idle), 64'd1);
      check($sformatf("b2b%0d_busy_cycles", op), 64'(cyc), 64'(BUSY_B10000));
      check($sformatf("b2b%0d_product", op), p_out, 64'h0000_0001_0000_0000);
      check($sformatf("b2b%0d_hold", op), {63'd0, stable}, 64'd1);
    end
    start_in = 1'b0;
    repeat (3) @(negedge clk);
    check("final_idle_busy", {63'd0, busy}, 64'd0);
    check("final_p", p_out, 64'h0000_0001_0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
